regbus_scan_reader: RTL and testbench

Reader side of the shared tri-state register bus. Each pipeline/memory register drives the bus only while its cs is low and floats it when cs is high. This block selects masked registers one at a time, waits a settle window, and captures the bus word. It returns each word with its index over a valid/ready stream to the debug/readback path of the FPGA CPU.

---
 rtl/regbus_scan_reader_pkg.sv | 16 +
 rtl/regbus_scan_reader_if.sv | 25 ++
 rtl/regbus_prio_pick.sv | 22 ++
 rtl/regbus_scan_reader.sv | 126 ++++++++++++
 tb/tb_regbus_scan_reader.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/regbus_scan_reader_pkg.sv
// Shared definitions for the register-bus scan reader: FSM encoding, index
// width and the legal range of the settle window.
package regbus_scan_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int IDX_W      = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

endpackage

// File: rtl/regbus_scan_reader_if.sv
// Tri-state register bus selects plus the valid/ready readback stream.
interface regbus_scan_reader_if #(
  parameter int NrOfBits = 32,
  parameter int NrOfRegs = 8
);
  import regbus_scan_reader_pkg::*;

  logic [NrOfRegs-1:0] cs;
  logic [NrOfBits-1:0] bus_data;
  logic                out_valid;
  logic                out_ready;
  logic [NrOfBits-1:0] out_data;
  logic [IDX_W-1:0]    out_index;

  modport master (
    output cs, out_valid, out_data, out_index,
    input  bus_data, out_ready
  );

  modport slave (
    input  cs, out_valid, out_data, out_index,
    output bus_data, out_ready
  );

endinterface

// File: rtl/regbus_prio_pick.sv
// Lowest-set-bit finder over the remaining scan mask.
module regbus_prio_pick
  import regbus_scan_reader_pkg::*;
#(
  parameter int NrOfRegs = 8
) (
  input  logic [NrOfRegs-1:0] mask_i,
  output logic [IDX_W-1:0]    idx_o,
  output logic                any_o
);

  always_comb begin
    idx_o = '0;
    // Walk downwards so the lowest set bit is the last one written.
    for (int i = NrOfRegs - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |mask_i;

endmodule

// File: rtl/regbus_scan_reader.sv
// Scans masked registers on the shared tri-state bus one at a time and
// returns each captured word with its index over a valid/ready stream.
module regbus_scan_reader
  import regbus_scan_reader_pkg::*;
#(
  parameter int NrOfBits     = 32,
  parameter int NrOfRegs     = 8,
  parameter int SettleCycles = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tick_i,
  input  logic                start_i,
  input  logic [NrOfRegs-1:0] mask_i,
  output logic                busy_o,
  output logic                done_o,
  regbus_scan_reader_if.master rb
);

  localparam int SETTLE_EFF = (SettleCycles < SETTLE_MIN) ? SETTLE_MIN :
                              (SettleCycles > SETTLE_MAX) ? SETTLE_MAX : SettleCycles;
  localparam logic [IDX_W-1:0]    SETTLE_LAST = IDX_W'(SETTLE_EFF - 1);
  localparam logic [NrOfRegs-1:0] REG_ONE     = NrOfRegs'(1);

  state_e              state_q, state_d;
  logic [NrOfRegs-1:0] mask_q, mask_d, pick_mask;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    out_index_q, out_index_d;
  logic [NrOfBits-1:0] out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  // In IDLE the picker looks at the incoming mask; afterwards at what is left
  // once the register just transferred is removed.
  always_comb begin
    pick_mask = mask_q & ~(REG_ONE << idx_q);
    if (state_q == ST_IDLE) pick_mask = mask_i;
  end

  regbus_prio_pick #(.NrOfRegs(NrOfRegs)) u_pick (
    .mask_i (pick_mask),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_index_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (tick_i) begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mask_d = mask_i;
            if (pick_any) begin
              idx_d   = pick_idx;
              cnt_d   = '0;
              state_d = ST_SELECT;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_SELECT: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == SETTLE_LAST) begin
            out_data_d  = rb.bus_data;
            out_index_d = idx_q;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (rb.out_ready) begin
            out_valid_d = 1'b0;
            mask_d      = pick_mask;
            if (pick_any) begin
              idx_d   = pick_idx;
              cnt_d   = '0;
              state_d = ST_SELECT;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Selects decode straight from registered state so reset releases the bus at once.
  assign rb.cs        = (state_q == ST_SELECT) ? ~(REG_ONE << idx_q) : '1;
  assign rb.out_valid = out_valid_q;
  assign rb.out_data  = out_data_q;
  assign rb.out_index = out_index_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_regbus_scan_reader.sv
// Scoreboard bench for regbus_scan_reader: stimulus pushes expected words
// from the mask, a monitor pops them on every stream transfer.
module tb_regbus_scan_reader;
  import regbus_scan_reader_pkg::*;

  localparam int W      = 32;
  localparam int N      = 8;
  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick_i, start_i, busy_o, done_o;
  logic [N-1:0] mask_i;
  logic         tick3, start3, busy3, done3;
  logic [N-1:0] mask3;

  regbus_scan_reader_if #(.NrOfBits(W), .NrOfRegs(N)) bif ();
  regbus_scan_reader_if #(.NrOfBits(W), .NrOfRegs(N)) bif3 ();

  regbus_scan_reader #(.NrOfBits(W), .NrOfRegs(N), .SettleCycles(SETTLE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick_i), .start_i(start_i),
    .mask_i(mask_i), .busy_o(busy_o), .done_o(done_o), .rb(bif.master));

  regbus_scan_reader #(.NrOfBits(W), .NrOfRegs(N), .SettleCycles(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick3), .start_i(start3),
    .mask_i(mask3), .busy_o(busy3), .done_o(done3), .rb(bif3.master));

  always #5 clk = ~clk;

  // Bus model: the register whose select is low drives; otherwise a marker word.
  logic [W-1:0] regs [N];
  always_comb begin
    bif.bus_data = 32'hDEAD_BEEF;
    for (int i = 0; i < N; i++)
      if (bif.cs == ~(N'(1) << i)) bif.bus_data = regs[i];
  end
  assign bif3.bus_data = bif3.cs[0] ? 32'hDEAD_BEEF : 32'hA5A5_0003;

  int          n_checks = 0, n_fail = 0;
  int          done_seen = 0, exp_done = 0;
  logic [35:0] exp_q [$];
  bit          tick_rand = 0, ready_rand = 0, ready_hold0 = 0;

  task automatic check(input bit ok, input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    tick_i        = tick_rand ? ($urandom_range(3) != 0) : 1'b1;
    bif.out_ready = ready_hold0 ? 1'b0 : (ready_rand ? 1'($urandom_range(1)) : 1'b1);
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < N; i++) regs[i] = $urandom;
  endtask

  // Returns one cycle after the edge that accepted Start.
  task automatic issue_start(input logic [N-1:0] m);
    for (int c = 0; c < 200 && busy_o; c++) cycle();
    check(!busy_o, "idle_wait", 64'(busy_o), 64'(0));
    start_i = 1'b1;
    mask_i  = m;
    for (int c = 0; c < 200 && !tick_i; c++) cycle();
    for (int i = 0; i < N; i++)
      if (m[i]) exp_q.push_back({4'(i), regs[i]});
    exp_done++;
    cycle();
    start_i = 1'b0;
    mask_i  = N'($urandom);
    check(busy_o === 1'b1, "busy_after_start", 64'(busy_o), 64'(1));
  endtask

  task automatic wait_done();
    for (int c = 0; c < 600 && done_seen < exp_done; c++) cycle();
    check(done_seen == exp_done, "done_count", 64'(done_seen), 64'(exp_done));
    check(exp_q.size() == 0, "words_left", 64'(exp_q.size()), 64'(0));
  endtask

  // Monitor: protocol invariants and scoreboard pops, sampled on the falling edge.
  logic [N-1:0] prev_cs;
  logic         prev_valid, prev_xfer, prev_done;
  logic [35:0]  prev_word, cur_word, e;
  int           low_ticks;
  initial begin
    prev_cs = '1; prev_valid = 0; prev_xfer = 0; prev_done = 0; low_ticks = 0;
    prev_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cs = '1; prev_valid = 0; prev_xfer = 0; prev_done = 0; low_ticks = 0;
      end else begin
        cur_word = {bif.out_index, bif.out_data};
        check($countones(~bif.cs) <= 1, "cs_single_select", 64'(bif.cs), 64'(8'hFF));
        if (bif.cs != 8'hFF) begin
          if (prev_cs != 8'hFF)
            check(bif.cs == prev_cs, "cs_no_gap", 64'(bif.cs), 64'(prev_cs));
          if (tick_i) low_ticks++;
        end else if (prev_cs != 8'hFF) begin
          check(low_ticks == SETTLE, "settle_ticks", 64'(low_ticks), 64'(SETTLE));
          low_ticks = 0;
        end
        if (bif.out_valid)
          check(bif.cs == 8'hFF, "cs_released_in_hold", 64'(bif.cs), 64'(8'hFF));
        if (prev_valid && !prev_xfer && bif.out_valid)
          check(cur_word == prev_word, "hold_stable", 64'(cur_word), 64'(prev_word));
        prev_xfer = bif.out_valid && bif.out_ready && tick_i;
        if (prev_xfer) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_word", 64'(cur_word), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check(cur_word == e, "word", 64'(cur_word), 64'(e));
          end
        end
        if (done_o && !prev_done) done_seen++;
        prev_done  = done_o;
        prev_valid = bif.out_valid;
        prev_word  = cur_word;
        prev_cs    = bif.cs;
      end
    end
  end

  int   low3, d3;
  logic vprev3, dprev3, last_tick3;

  initial begin
    rst_n = 1'b0; tick_i = 1'b1; start_i = 1'b0; mask_i = '0; bif.out_ready = 1'b1;
    tick3 = 1'b0; start3 = 1'b0; mask3 = '0; bif3.out_ready = 1'b1;
    randomize_regs();
    repeat (2) @(posedge clk);
    #1;
    check(bif.cs == 8'hFF, "rst_cs", 64'(bif.cs), 64'(8'hFF));
    check(!bif.out_valid && !busy_o && !done_o, "rst_flags",
          64'({bif.out_valid, busy_o, done_o}), 64'(0));
    check(bif.out_data == 0 && bif.out_index == 0, "rst_out",
          64'({bif.out_index, bif.out_data}), 64'(0));
    rst_n = 1'b1;

    // Two-register scan with exact latency.
    regs[0] = 32'h1111_1111; regs[2] = 32'h2222_2222;
    issue_start(8'h05);
    @(negedge clk); check(bif.cs == 8'hFE, "t1_cs_c1", 64'(bif.cs), 64'(8'hFE));
    @(negedge clk); check(bif.cs == 8'hFE, "t1_cs_c2", 64'(bif.cs), 64'(8'hFE));
    @(negedge clk);
    check(bif.out_valid && bif.out_index == 0 && bif.out_data == 32'h1111_1111, "t1_word0_c3",
          64'({bif.out_valid, bif.out_index, bif.out_data}), 64'({1'b1, 4'd0, 32'h1111_1111}));
    wait_done();

    // Empty mask: Done on the cycle after Start, Busy for that one cycle.
    issue_start(8'h00);
    check(done_o && bif.cs == 8'hFF, "t2_done", 64'({done_o, bif.cs}), 64'({1'b1, 8'hFF}));
    cycle();
    check(!busy_o && !done_o, "t2_idle", 64'({busy_o, done_o}), 64'(0));
    wait_done();

    // Backpressure on register 7.
    randomize_regs();
    ready_hold0 = 1; bif.out_ready = 1'b0;
    issue_start(8'h80);
    for (int c = 0; c < 50 && !bif.out_valid; c++) cycle();
    repeat (10) begin
      cycle();
      check(bif.out_valid && bif.out_index == 7 && bif.cs == 8'hFF, "t3_held",
            64'({bif.out_valid, bif.out_index, bif.cs}), 64'({1'b1, 4'd7, 8'hFF}));
    end
    ready_hold0 = 0; bif.out_ready = 1'b1;
    @(posedge clk); #1;
    check(done_o && !bif.out_valid, "t3_done_after_xfer",
          64'({done_o, bif.out_valid}), 64'({1'b1, 1'b0}));
    wait_done();

    // Tick every other cycle, SettleCycles=3 instance.
    @(posedge clk); #1 tick3 = 1'b1; start3 = 1'b1; mask3 = 8'h01;
    @(posedge clk); #1 start3 = 1'b0; mask3 = 8'hFF; tick3 = 1'b0;
    low3 = 0; d3 = 0; vprev3 = 0; dprev3 = 0; last_tick3 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!bif3.cs[0]) low3++;
      if (bif3.out_valid && !vprev3) begin
        check(last_tick3 == 1'b1, "t4_capture_on_tick", 64'(last_tick3), 64'(1));
        check(bif3.out_data == 32'hA5A5_0003 && bif3.out_index == 0, "t4_word",
              64'({bif3.out_index, bif3.out_data}), 64'({4'd0, 32'hA5A5_0003}));
      end
      if (done3 && !dprev3) d3++;
      vprev3 = bif3.out_valid; dprev3 = done3;
      @(posedge clk); last_tick3 = tick3;
      #1 tick3 = ~tick3;
    end
    check(low3 == 6, "t4_cs_low_cycles", 64'(low3), 64'(6));
    check(d3 == 1 && !busy3, "t4_done", 64'({d3[3:0], busy3}), 64'({4'd1, 1'b0}));

    // Asynchronous reset in the middle of a select.
    randomize_regs();
    issue_start(8'h10);
    for (int c = 0; c < 50 && bif.cs != 8'hEF; c++) cycle();
    check(bif.cs == 8'hEF, "t5_in_select", 64'(bif.cs), 64'(8'hEF));
    #2 rst_n = 1'b0;
    #1;
    check(bif.cs == 8'hFF && !bif.out_valid && !busy_o, "t5_async_reset",
          64'({bif.cs, bif.out_valid, busy_o}), 64'({8'hFF, 1'b0, 1'b0}));
    exp_q.delete();
    exp_done = done_seen;
    @(posedge clk); #1 rst_n = 1'b1;
    issue_start(8'h5A);
    wait_done();

    // Start with a different mask during a scan is ignored.
    randomize_regs();
    issue_start(8'h05);
    cycle(); cycle();
    start_i = 1'b1; mask_i = 8'hF0;
    cycle(); cycle(); cycle();
    start_i = 1'b0;
    wait_done();

    // Randomised scans with random Tick and OutReady.
    tick_rand = 1; ready_rand = 1;
    repeat (25) begin
      randomize_regs();
      issue_start(($urandom_range(4) == 0) ? 8'h00 : N'($urandom));
      wait_done();
    end
    tick_rand = 0; ready_rand = 0;
    repeat (3) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
